ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle RV32M execute unit that sits beside the single-cycle ALU/shifter in the EX stage. It covers all eight M-extension operations: a pipelined multiply of configurable latency and an iterative radix-2 divide. It talks to the stage through valid/ready handshakes, so EX stalls only while the unit is busy. Branch redirects kill in-flight work through a flush input.

---
 rtl/ex_muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execute unit: pipelined multiply of configurable latency
// plus an iterative restoring divider, with valid/ready handshakes on both sides.
module ex_muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W  = $clog2(XLEN) + 1;
    localparam int MCNT_W = $clog2(MUL_LAT) + 1;

    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(XLEN);
    localparam logic [MCNT_W-1:0] MUL_LAST = MCNT_W'(MUL_LAT - 1);
    localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state;

    logic [CNT_W-1:0]  div_cnt;
    logic [MCNT_W-1:0] mul_cnt;

    // Operation context captured at accept
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [TAG_W-1:0]  tag_q;

    // Divider working registers
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvs;
    logic              q_neg;
    logic              r_neg;

    // Accept-side decode
    logic              in_signed;
    logic              in_a_neg;
    logic              in_b_neg;
    logic [XLEN-1:0]   in_a_mag;
    logic [XLEN-1:0]   in_b_mag;
    logic              div_by_zero;
    logic              div_ovf;
    logic              accept;

    always_comb begin
        in_signed   = ~in_funct3[0];
        in_a_neg    = in_signed & in_a[XLEN-1];
        in_b_neg    = in_signed & in_b[XLEN-1];
        in_a_mag    = in_a_neg ? -in_a : in_a;
        in_b_mag    = in_b_neg ? -in_b : in_b;
        div_by_zero = (in_b == '0);
        div_ovf     = in_signed && (in_a == INT_MIN) && (in_b == '1);
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_MUL) || (state == S_DIV);
    assign accept   = in_valid & in_ready & ~flush;

    // Multiply datapath: extend per funct3, then one full 2*XLEN product
    logic                mul_a_sgn;
    logic                mul_b_sgn;
    logic [2*XLEN-1:0]   mul_a_ext;
    logic [2*XLEN-1:0]   mul_b_ext;
    logic [2*XLEN-1:0]   product;
    logic [XLEN-1:0]     mul_result;

    always_comb begin
        mul_a_sgn  = (op_q != 2'b11);
        mul_b_sgn  = ~op_q[1];
        mul_a_ext  = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
        mul_b_ext  = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
        product    = mul_a_ext * mul_b_ext;
        mul_result = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    // Divide datapath: one restoring shift-subtract step, plus final sign fix
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] div_result;

    always_comb begin
        shifted    = {rem, quo[XLEN-1]};
        diff       = shifted - {1'b0, dvs};
        q_fix      = q_neg ? -quo : quo;
        r_fix      = r_neg ? -rem : rem;
        div_result = op_q[1] ? r_fix : q_fix;
    end

    // NOTE: all state registers are written with non-blocking assignments so every
    // always_ff sees the pre-edge values of the others, whatever the evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            mul_cnt    <= '0;
            div_cnt    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!in_funct3[2]) begin
                            state   <= S_MUL;
                            mul_cnt <= '0;
                        end else begin
                            // Special cases skip the iterations and only take the sign-fix step
                            state   <= S_DIV;
                            div_cnt <= (div_by_zero || div_ovf) ? DIV_LAST : '0;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_cnt == MUL_LAST) begin
                        state      <= S_DONE;
                        out_valid  <= 1'b1;
                        out_result <= mul_result;
                        out_tag    <= tag_q;
                    end else begin
                        mul_cnt <= mul_cnt + MCNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (div_cnt == DIV_LAST) begin
                        state      <= S_DONE;
                        out_valid  <= 1'b1;
                        out_result <= div_result;
                        out_tag    <= tag_q;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; each is loaded at accept before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= in_funct3[1:0];
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            dvs   <= in_b_mag;
            if (div_by_zero) begin
                quo   <= '1;
                rem   <= in_a;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
            end else if (div_ovf) begin
                quo   <= in_a;
                rem   <= '0;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
            end else begin
                quo   <= in_a_mag;
                rem   <= '0;
                q_neg <= in_a_neg ^ in_b_neg;
                r_neg <= in_a_neg;
            end
        end else if (state == S_DIV && div_cnt != DIV_LAST) begin
            if (!diff[XLEN]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: transaction-level reference model checked
// every cycle, directed literal cases, and a randomized handshake/flush phase.
module tb_ex_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct3 (in_funct3),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of an M-extension op, straight from the ISA rules
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        logic       ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Transaction model: idle, working for a fixed latency, or holding a result
    typedef enum {M_IDLE, M_WORK, M_DONE} mst_t;
    mst_t             m_st = M_IDLE;
    logic [31:0]      m_res = '0;
    logic [TAG_W-1:0] m_tag = '0;
    bit               m_valid = 1'b0;
    bit               m_known = 1'b0;
    bit               chk_en = 1'b0;
    int               m_left = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_st    <= M_IDLE;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_tag   <= '0;
            m_known <= 1'b1;
            chk_en  <= 1'b1;
        end else if (flush) begin
            m_st    <= M_IDLE;
            m_valid <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (in_valid) begin
                    m_res   <= ref_op(in_funct3, in_a, in_b);
                    m_tag   <= in_tag;
                    m_left  <= lat_of(in_funct3, in_a, in_b);
                    m_st    <= M_WORK;
                    m_known <= 1'b0;
                    n_acc   <= n_acc + 1;
                end
                M_WORK: begin
                    if (m_left == 1) begin
                        m_st    <= M_DONE;
                        m_valid <= 1'b1;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: if (out_ready) begin
                    m_st    <= M_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, m_st == M_IDLE);
            check("busy", busy, m_st == M_WORK);
            check("out_valid", out_valid, m_valid);
            if (m_valid || m_known) begin
                check("out_result", out_result, m_res);
                check("out_tag", out_tag, m_tag);
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) check("wait_idle_timeout", 0, 1);
    endtask

    // Called just after the accept edge; measures latency and checks the result
    task automatic wait_result(input string name, input logic [31:0] exp,
                               input logic [TAG_W-1:0] tag, input int lat);
        int k;
        bit got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
        else begin
            check({name, "_lat"}, k, lat);
            check({name, "_res"}, out_result, exp);
            check({name, "_tag"}, out_tag, tag);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        in_funct3 = f;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        in_valid  = 1'b1;
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp, input int lat);
        wait_idle();
        drive(f, a, b, tag);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(name, exp, tag, lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit seen;
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", out_result, 0);
        check("rst_tag", out_tag, 0);

        check("model_mulhu", ref_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_rem", ref_op(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_div_ovf", ref_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        do_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd17, 32'hFFFF_FFEB, 2);
        do_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 2);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 2);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 2);
        do_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 33);
        do_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF, 33);
        do_op("divu",   3'b101, 32'd100,        32'd7,         5'd6,  32'd14,        33);
        do_op("remu",   3'b111, 32'd100,        32'd7,         5'd7,  32'd2,         33);
        do_op("divu0",  3'b101, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 1);
        do_op("rem0",   3'b110, 32'd5,          32'd0,         5'd9,  32'd5,         1);
        do_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        do_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0,         1);

        // Backpressure with a second op waiting on the input
        wait_idle();
        out_ready = 1'b0;
        drive(3'b101, 32'd100, 32'd7, 5'd9);
        @(posedge clk);
        #1 drive(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd21);
        wait_result("bp_first", 32'd14, 5'd9, 33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_res", out_result, 32'd14);
            check("bp_hold_tag", out_tag, 5'd9);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_hs_valid", out_valid, 0);
        check("bp_after_hs_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("bp_second", 32'hFFFF_FFEB, 5'd21, 2);

        // Flush in the middle of a divide
        wait_idle();
        drive(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd12);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        seen = out_valid;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("flush_no_valid", seen, 0);

        // Reset in the middle of a multiply
        wait_idle();
        drive(3'b000, 32'd3, 32'd5, 5'd30);
        @(posedge clk);
        #1 in_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_result", out_result, 0);
        check("midrst_tag", out_tag, 0);

        // Flush together with in_valid in IDLE: no accept
        wait_idle();
        drive(3'b000, 32'd3, 32'd5, 5'd31);
        flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", in_ready, 1);
        check("flush_idle_busy", busy, 0);
        check("flush_idle_valid", out_valid, 0);

        // Randomized traffic with backpressure and occasional flushes
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_funct3 = 3'($urandom);
            in_a      = pick();
            in_b      = pick();
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("random_accepts", n_acc > 40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
